// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads the instruction ROM and buffers
// {pc, instr} pairs in a small prefetch FIFO for the decode stage.
module instr_fetch_ctrl #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc
);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_HALT  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]    state;
    logic [63:0]   pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [63:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];

    logic pop, push, redir, pc_good, target_good, full, seq_fault;

    // 65-bit compare so addr+3 cannot wrap past the top of the address space
    function automatic logic addr_good(input logic [63:0] a);
        return (a[1:0] == 2'b00) && (({1'b0, a} + 65'd3) < 65'(MEM_SIZE));
    endfunction

    always_comb begin
        full        = (count == (PW+1)'(DEPTH));
        pop         = out_valid && out_ready;
        redir       = redirect_valid && (state != S_FAULT);
        pc_good     = addr_good(pc);
        target_good = addr_good(redirect_pc);
        push        = (state == S_RUN) && !halt && !redir && pc_good && (!full || out_ready);
        seq_fault   = (state == S_RUN) && !halt && !redir && !pc_good;
    end

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= imem_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_RUN;
            pc       <= 64'(RESET_PC);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (redir) begin
            // Flush drops every entry, including a head popped this same cycle
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (target_good) begin
                pc    <= redirect_pc;
                state <= halt ? S_HALT : S_RUN;
            end else begin
                state    <= S_FAULT;
                fault    <= 1'b1;
                fault_pc <= redirect_pc;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc + 64'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);

            case (state)
                S_RUN: begin
                    if (halt)
                        state <= S_HALT;
                    else if (seq_fault) begin
                        state    <= S_FAULT;
                        fault    <= 1'b1;
                        fault_pc <= pc;
                    end
                end
                S_HALT:  if (!halt) state <= S_RUN;
                default: state <= S_FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; ROM word at byte address a reads 0x1000_0000 + a/4.
module tb_instr_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_instr = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    instr_fetch_ctrl #(.MEM_SIZE(1024), .RESET_PC(0), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;

        // 1: reset state, then streaming with out_ready=1
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_fault_pc", fault_pc, 64'd0);
        reset_n = 1'b1; out_ready = 1'b1;
        step();
        chk("s1_valid", 64'(out_valid), 64'd1);
        chk("s1_pc0", out_pc, 64'h0);
        chk("s1_instr0", 64'(out_instr), 64'h1000_0000);
        step(); chk("s1_pc4", out_pc, 64'h4);
        step(); chk("s1_pc8", out_pc, 64'h8);
        step(); chk("s1_pc12", out_pc, 64'hC);
        chk("s1_instr12", 64'(out_instr), 64'h1000_0003);

        // 2: backpressure fills FIFO, release delivers in order
        do_reset(); out_ready = 1'b0;
        repeat (5) step();
        chk("s2_full_valid", 64'(out_valid), 64'd1);
        chk("s2_hold_pc", out_pc, 64'h0);
        chk("s2_pc_held", imem_addr, 64'h8);
        out_ready = 1'b1;
        step(); chk("s2_d4", out_pc, 64'h4);
        chk("s2_d4_instr", 64'(out_instr), 64'h1000_0001);
        step(); chk("s2_d8", out_pc, 64'h8);
        step(); chk("s2_d12", out_pc, 64'hC);

        // 3: redirect flushes two buffered entries
        do_reset(); out_ready = 1'b0;
        repeat (2) step();
        chk("s3_pre_valid", 64'(out_valid), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        chk("s3_flushed", 64'(out_valid), 64'd0);
        chk("s3_addr", imem_addr, 64'h40);
        redirect_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("s3_tgt_pc", out_pc, 64'h40);
        chk("s3_tgt_instr", 64'(out_instr), 64'h1000_0010);

        // 4: misaligned and out-of-range redirect targets
        redirect_valid = 1'b1; redirect_pc = 64'h42;
        step();
        redirect_valid = 1'b0;
        chk("s4_fault", 64'(fault), 64'd1);
        chk("s4_fault_pc", fault_pc, 64'h42);
        chk("s4_pc_kept", imem_addr, 64'h44);
        step(); step();
        chk("s4_no_push", 64'(out_valid), 64'd0);
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 64'h400;
        step();
        redirect_valid = 1'b0;
        chk("s4_oob_fault", 64'(fault), 64'd1);
        chk("s4_oob_fault_pc", fault_pc, 64'h400);

        // 5: sequential run off the end of the ROM
        do_reset(); out_ready = 1'b1;
        chk("s5_fault_cleared", 64'(fault), 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h3F0;
        step();
        redirect_valid = 1'b0;
        step(); chk("s5_3f0", out_pc, 64'h3F0);
        step(); chk("s5_3f4", out_pc, 64'h3F4);
        step(); chk("s5_3f8", out_pc, 64'h3F8);
        step(); chk("s5_3fc", out_pc, 64'h3FC);
        chk("s5_3fc_instr", 64'(out_instr), 64'h1000_00FF);
        chk("s5_no_fault_yet", 64'(fault), 64'd0);
        step();
        chk("s5_fault", 64'(fault), 64'd1);
        chk("s5_fault_pc", fault_pc, 64'h400);
        chk("s5_drained", 64'(out_valid), 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        step();
        redirect_valid = 1'b0;
        chk("s5_redir_ignored", imem_addr, 64'h400);

        // 6: halt drains, halt+redirect, reset with full FIFO
        do_reset(); out_ready = 1'b0;
        repeat (2) step();
        halt = 1'b1; out_ready = 1'b1;
        step(); chk("s6_drain4", out_pc, 64'h4);
        step(); chk("s6_empty", 64'(out_valid), 64'd0);
        step(); chk("s6_pc_hold", imem_addr, 64'h8);
        chk("s6_still_empty", 64'(out_valid), 64'd0);
        halt = 1'b0;
        step(); chk("s6_resume_gap", 64'(out_valid), 64'd0);
        step(); chk("s6_resume_pc", out_pc, 64'h8);
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h80;
        step();
        redirect_valid = 1'b0;
        chk("s6_hr_flush", 64'(out_valid), 64'd0);
        chk("s6_hr_addr", imem_addr, 64'h80);
        step(); chk("s6_hr_hold", 64'(out_valid), 64'd0);
        halt = 1'b0;
        step(); step();
        chk("s6_hr_pc", out_pc, 64'h80);
        chk("s6_hr_instr", 64'(out_instr), 64'h1000_0020);
        out_ready = 1'b0;
        step(); step();
        chk("s6_full_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        step();
        chk("s6_rst_valid", 64'(out_valid), 64'd0);
        chk("s6_rst_addr", imem_addr, 64'h0);
        chk("s6_rst_pc", out_pc, 64'h0);
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
